// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding, default
// parameter values and a counter-width helper.
package pll_reset_sequencer_pkg;

    typedef enum logic [2:0] {
        StHold,
        StWaitLock,
        StStabilize,
        StRelease,
        StRun,
        StFail
    } state_e;

    localparam int unsigned DefPllRstCycles     = 16;
    localparam int unsigned DefLockStableCycles = 1024;
    localparam int unsigned DefLockTimeout      = 65536;
    localparam int unsigned DefNumRst           = 4;
    localparam int unsigned DefStaggerCycles    = 8;
    localparam int unsigned DefMaxRetries       = 3;

    // Width of a counter that must index max_count distinct values, minimum 1 bit.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for bringing asynchronous level signals into a clock domain.
module sync_2ff #(
    parameter int unsigned     Width    = 1,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives the board PLL reset, qualifies lock, and releases per-domain core resets
// in a fixed stagger; retries on lock timeout and latches a fail state.
module pll_reset_sequencer
    import pll_reset_sequencer_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES     = DefPllRstCycles,
    parameter int unsigned LOCK_STABLE_CYCLES = DefLockStableCycles,
    parameter int unsigned LOCK_TIMEOUT       = DefLockTimeout,
    parameter int unsigned NUM_RST            = DefNumRst,
    parameter int unsigned STAGGER_CYCLES     = DefStaggerCycles,
    parameter int unsigned MAX_RETRIES        = DefMaxRetries
) (
    input  logic                                   refclk,
    input  logic                                   rst,
    input  logic                                   pll_locked,
    input  logic                                   relock_req,
    output logic                                   pll_rst,
    output logic [NUM_RST-1:0]                     rst_out,
    output logic                                   ready,
    output logic                                   fail,
    output logic [cnt_width(MAX_RETRIES + 1)-1:0] retry_cnt
);

    localparam int unsigned RetryW   = cnt_width(MAX_RETRIES + 1);
    localparam int unsigned MaxA     = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                       PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned MaxB     = (LOCK_TIMEOUT > NUM_RST * STAGGER_CYCLES) ?
                                       LOCK_TIMEOUT : NUM_RST * STAGGER_CYCLES;
    localparam int unsigned MaxCount = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned TimerW   = cnt_width(MaxCount);

    localparam logic [TimerW-1:0] HoldLast    = TimerW'(PLL_RST_CYCLES - 1);
    localparam logic [TimerW-1:0] TimeoutLast = TimerW'(LOCK_TIMEOUT - 1);
    localparam logic [TimerW-1:0] StableLast  = TimerW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TimerW-1:0] ReleaseLast = TimerW'((NUM_RST - 1) * STAGGER_CYCLES);

    logic lock_s;

    sync_2ff #(
        .Width    (1),
        .ResetVal (1'b0)
    ) u_lock_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (pll_locked),
        .q_o   (lock_s)
    );

    state_e              state_q, state_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [RetryW-1:0]   retry_q, retry_d;
    logic [NUM_RST-1:0]  rst_out_q, rst_out_d;
    logic                pll_rst_q, ready_q, fail_q;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        timer_d = timer_q + 1'b1;

        unique case (state_q)
            StHold: begin
                if (timer_q == HoldLast) state_d = StWaitLock;
            end
            StWaitLock: begin
                if (lock_s) begin
                    state_d = StStabilize;
                end else if (timer_q == TimeoutLast) begin
                    if (retry_q < RetryW'(MAX_RETRIES)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = StHold;
                    end else begin
                        state_d = StFail;
                    end
                end
            end
            StStabilize: begin
                if (!lock_s) state_d = StWaitLock;
                else if (timer_q == StableLast) state_d = StRelease;
            end
            StRelease: begin
                if (!lock_s) state_d = StHold;
                else if (timer_q == ReleaseLast) state_d = StRun;
            end
            StRun: begin
                if (!lock_s) state_d = StHold;
            end
            StFail: begin
                state_d = StFail;
            end
            default: state_d = StHold;
        endcase

        if (relock_req) begin
            state_d = StHold;
            retry_d = '0;
        end

        // Re-entry of HOLD by relock_req also restarts the timer.
        if (relock_req || (state_d != state_q)) timer_d = '0;

        // Outputs are derived from the next state so they register in step with it.
        rst_out_d = '1;
        for (int unsigned i = 0; i < NUM_RST; i++) begin
            if ((state_d == StRun) ||
                ((state_d == StRelease) && (32'(timer_d) >= i * STAGGER_CYCLES))) begin
                rst_out_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= StHold;
            timer_q   <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            pll_rst_q <= (state_d == StHold) || (state_d == StFail);
            rst_out_q <= rst_out_d;
            ready_q   <= (state_d == StRun);
            fail_q    <= (state_d == StFail);
        end
    end

    assign pll_rst   = pll_rst_q;
    assign rst_out   = rst_out_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;

endmodule
